// File: rtl/ram_fifo_pkg.sv
// ============================================================================
// ram_fifo_pkg : shared elaboration helpers for the ram_fifo block
// Revision     : 1.0
// ============================================================================
`default_nettype none

package ram_fifo_pkg;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_fifo_ram.sv
// ============================================================================
// ram : simple dual-port RAM with registered read and read-priority conflicts
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SIZE  = 512
) (
  input  logic                    wrclk,
  input  logic                    wren,
  input  logic [$clog2(SIZE)-1:0] wraddr,
  input  logic [WIDTH-1:0]        wrdata,
  input  logic                    rdclk,
  input  logic                    rden,
  input  logic [$clog2(SIZE)-1:0] rdaddr,
  output logic [WIDTH-1:0]        rddata
);

  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] rddata_q;
  logic [WIDTH-1:0] rddata_d;

  // A simultaneous read of the written address wins; the write is dropped.
  always_ff @(posedge wrclk) begin
    if (wren && !(rden && (rdaddr == wraddr))) begin
      mem[wraddr] <= wrdata;
    end
  end

  always_comb begin
    rddata_d = rddata_q;
    if (rden) begin
      rddata_d = mem[rdaddr];
    end
  end

  always_ff @(posedge rdclk) begin
    rddata_q <= rddata_d;
  end

  assign rddata = rddata_q;

endmodule

`default_nettype wire

// File: rtl/ram_fifo.sv
// ============================================================================
// ram_fifo : single-clock first-word-fall-through FIFO around one ram instance
//            Optional almost_full flag enabled by RAM_FIFO_ALMOST_FULL_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int SIZE        = 512,
  parameter int ALMOST_FULL = SIZE - 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(SIZE+2)-1:0] count,
  output logic                      almost_full
);

  localparam int ABITS = $clog2(SIZE);
  localparam int CBITS = $clog2(SIZE + 2);
  localparam logic [CBITS-1:0] MEM_FULL = CBITS'(SIZE);

  if (!is_pow2(SIZE)) begin : g_size_check
    $error("ram_fifo: SIZE must be a power of two and at least 2");
  end

  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CBITS-1:0] mem_count_q, mem_count_d;
  logic             out_valid_q, out_valid_d;
  logic             wren;
  logic             rden;

  always_comb begin
    in_ready    = !rst && (mem_count_q != MEM_FULL);
    wren        = in_valid && in_ready;
    // Prefetch the next word whenever the head slot is empty or being drained.
    rden        = !rst && (mem_count_q != '0) && (!out_valid_q || out_ready);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q;

    if (wren) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rden) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({wren, rden})
      2'b10:   mem_count_d = mem_count_q + 1'b1;
      2'b01:   mem_count_d = mem_count_q - 1'b1;
      default: mem_count_d = mem_count_q;
    endcase

    if (rden) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  ram #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_ram (
    .wrclk  (clk),
    .wren   (wren),
    .wraddr (wr_ptr_q),
    .wrdata (in_data),
    .rdclk  (clk),
    .rden   (rden),
    .rdaddr (rd_ptr_q),
    .rddata (out_data)
  );

  assign out_valid = out_valid_q;
  assign count     = mem_count_q + CBITS'(out_valid_q);

`ifdef RAM_FIFO_ALMOST_FULL_EN
  if (ALMOST_FULL > SIZE + 1) begin : g_af_check
    $error("ram_fifo: ALMOST_FULL must not exceed SIZE+1");
  end
  assign almost_full = (count >= CBITS'(ALMOST_FULL));
`else
  logic [31:0] af_unused;
  assign af_unused   = 32'(ALMOST_FULL);
  assign almost_full = 1'b0;
`endif

endmodule

`default_nettype wire
